fp16_acc_seq: RTL and testbench

- Sequencing stage wrapped around the FP16 adder. It turns a stream of FP16 values into one FP16 sum per vector of VEC_LEN elements.
- Buffers incoming elements in a small FIFO. Issues one add at a time to the adder (adder input_valid/data1/data2) and waits for the adder's output_update/data_o before issuing the next.
- Feeds the adder and consumes its result; holds the running sum in a local accumulator.

---
 rtl/fp16_acc_seq_if.sv | 28 ++
 rtl/fp16_acc_seq.sv | 166 ++++++++++++++++
 tb/tb_fp16_acc_seq.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp16_acc_seq_if.sv
// Stream-in / adder / sum-out bundle for the FP16 reduction sequencer.
// slave is the sequencer side; master is whoever feeds it and hosts the adder.
interface fp16_acc_seq_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        add_valid;
    logic [15:0] add_data1;
    logic [15:0] add_data2;
    logic [15:0] add_result;
    logic        add_update;
    logic [15:0] sum_o;
    logic        sum_valid;
    logic        busy;
    logic        err_timeout;

    modport slave (
        input  in_valid, in_data, add_result, add_update,
        output in_ready, add_valid, add_data1, add_data2,
               sum_o, sum_valid, busy, err_timeout
    );

    modport master (
        output in_valid, in_data, add_result, add_update,
        input  in_ready, add_valid, add_data1, add_data2,
               sum_o, sum_valid, busy, err_timeout
    );
endinterface

// File: rtl/fp16_acc_seq.sv
// FP16 vector reduction sequencer: buffers elements in a small FIFO, issues one
// add at a time to an external FP16 adder and emits one sum per VEC_LEN elements.
// Values are never decoded here; the adder owns all arithmetic.
module fp16_acc_seq #(
    parameter int VEC_LEN     = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADD_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    fp16_acc_seq_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int TW = $clog2(ADD_TIMEOUT + 1);

    // cnt counts elements folded into acc; the last add is the one that
    // starts with cnt == VEC_LEN-1.
    localparam logic [CW-1:0] CNT_LAST  = CW'(VEC_LEN - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(ADD_TIMEOUT - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    logic [15:0]     acc;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   timer;
    logic            add_valid_r;
    logic [15:0]     add_data1_r;
    logic [15:0]     add_data2_r;
    logic [15:0]     sum_r;
    logic            sum_valid_r;
    logic            err_r;

    // ---------------- input FIFO ----------------
    logic [15:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            empty;
    logic            full;
    logic            in_ready;
    logic            push;
    logic            pop;
    logic [15:0]     head;

    assign empty    = (count == '0);
    assign full     = (count == FIFO_FULL);
    // Ready depends on registered state only: a full FIFO refuses even when
    // the sequencer is popping in the same cycle.
    assign in_ready = !full && (state != S_ERR);
    assign push     = bus.in_valid && in_ready;
    // LOAD is only reached with the FIFO non-empty and nothing else pops,
    // so the LOAD pop never underflows.
    assign pop      = (state == S_LOAD) || ((state == S_ISSUE) && !empty);
    assign head     = mem[rd_ptr];

    // Storage write; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.in_data;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- sequencing FSM ----------------
    // Drives the adder one operation at a time and owns the running sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            acc         <= '0;
            cnt         <= '0;
            timer       <= '0;
            add_valid_r <= 1'b0;
            add_data1_r <= '0;
            add_data2_r <= '0;
            sum_r       <= '0;
            sum_valid_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            add_valid_r <= 1'b0;
            sum_valid_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!empty)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    acc   <= head;
                    cnt   <= CW'(1);
                    state <= (VEC_LEN == 1) ? S_DONE : S_ISSUE;
                end
                S_ISSUE: begin
                    if (!empty) begin
                        add_data1_r <= acc;
                        add_data2_r <= head;
                        add_valid_r <= 1'b1;
                        timer       <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Operands stay on add_data1/2 until the adder answers.
                    if (bus.add_update) begin
                        acc   <= bus.add_result;
                        cnt   <= cnt + 1'b1;
                        state <= (cnt == CNT_LAST) ? S_DONE : S_ISSUE;
                    end else if (timer == TMR_LAST) begin
                        err_r <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DONE: begin
                    sum_r       <= acc;
                    sum_valid_r <= 1'b1;
                    state       <= S_IDLE;
                end
                S_ERR: begin
                    // Terminal: only reset leaves this state.
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.add_valid   = add_valid_r;
    assign bus.add_data1   = add_data1_r;
    assign bus.add_data2   = add_data2_r;
    assign bus.sum_o       = sum_r;
    assign bus.sum_valid   = sum_valid_r;
    assign bus.busy        = (state != S_IDLE) || !empty;
    assign bus.err_timeout = err_r;

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Scoreboard bench for fp16_acc_seq: a real-arithmetic reference predicts every
// adder issue and every sum; a monitor compares them as the DUT presents them.
module tb_fp16_acc_seq;

    localparam int VL = 4;
    localparam int FD = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_acc_seq_if bus ();
    fp16_acc_seq_if bus1 ();

    fp16_acc_seq #(.VEC_LEN(VL), .FIFO_DEPTH(FD), .ADD_TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fp16_acc_seq #(.VEC_LEN(1), .FIFO_DEPTH(FD), .ADD_TIMEOUT(TO)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- helpers ----------------
    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event occurred (cycle %0d), none expected", name, cyc);
    endtask

    function automatic real p2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else repeat (-k) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp2r(input logic [15:0] h);
        real m;
        int  e;
        e = int'(h[14:10]);
        if (e == 0) m = real'(h[9:0]) * p2(-24);
        else        m = (1.0 + real'(h[9:0]) / 1024.0) * p2(e - 15);
        return h[15] ? -m : m;
    endfunction

    // Round-to-nearest-even encode; stimulus stays in the normal range.
    function automatic logic [15:0] r2fp(input real r);
        real  a;
        real  mf;
        int   e;
        int   mi;
        logic s;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        a = s ? -r : r;
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        mf = (a - 1.0) * 1024.0;
        mi = $rtoi(mf);
        if ((mf - mi > 0.5) || ((mf - mi == 0.5) && mi[0])) mi++;
        if (mi == 1024) begin mi = 0; e++; end
        return {s, 5'(e + 15), 10'(mi)};
    endfunction

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] exp_iss[$];
    logic [15:0] exp_sum[$];
    logic [15:0] exp_sum1[$];
    real m_part;
    int  m_idx = 0;

    task automatic model_push(input logic [15:0] d);
        if (m_idx == 0) m_part = fp2r(d);
        else begin
            exp_iss.push_back({r2fp(m_part), d});
            m_part = m_part + fp2r(d);
        end
        m_idx++;
        if (m_idx == VL) begin
            exp_sum.push_back(r2fp(m_part));
            m_idx = 0;
        end
    endtask

    task automatic model_flush();
        exp_iss.delete();
        exp_sum.delete();
        m_idx = 0;
    endtask

    // ---------------- monitor ----------------
    int n_iss = 0, n_sum = 0, n_sum1 = 0;
    int last_iss_cyc = 0, last_sum_cyc = 0, last_sum1_cyc = 0;
    logic prev_av = 1'b0, prev_sv = 1'b0;

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (bus.add_valid) begin
                n_iss++;
                last_iss_cyc = cyc;
                check_int("add_valid_single_cycle", prev_av, 0);
                if (exp_iss.size() == 0) fail_evt("unexpected_add_valid");
                else begin
                    e = exp_iss.pop_front();
                    check16("add_data1", bus.add_data1, e[31:16]);
                    check16("add_data2", bus.add_data2, e[15:0]);
                end
            end
            if (bus.sum_valid) begin
                n_sum++;
                last_sum_cyc = cyc;
                check_int("sum_valid_single_cycle", prev_sv, 0);
                if (exp_sum.size() == 0) fail_evt("unexpected_sum_valid");
                else check16("sum_o", bus.sum_o, exp_sum.pop_front());
            end
            if (bus1.add_valid) fail_evt("vl1_add_valid");
            if (bus1.sum_valid) begin
                n_sum1++;
                last_sum1_cyc = cyc;
                if (exp_sum1.size() == 0) fail_evt("vl1_unexpected_sum_valid");
                else check16("vl1_sum_o", bus1.sum_o, exp_sum1.pop_front());
            end
            prev_av = bus.add_valid;
            prev_sv = bus.sum_valid;
        end
    end

    // ---------------- adder model ----------------
    int   adder_lat = 2;
    logic adder_hang = 1'b0;
    int   inject_cnt = 0;

    initial begin
        logic [15:0] d1, d2;
        int inj_done;
        inj_done = 0;
        bus.add_update = 1'b0;
        bus.add_result = '0;
        forever begin
            @(posedge clk); #1;
            if (inject_cnt > inj_done) begin
                inj_done++;
                bus.add_result = 16'h1234;
                bus.add_update = 1'b1;
                @(posedge clk); #1;
                bus.add_update = 1'b0;
            end else if (bus.add_valid && !adder_hang) begin
                d1 = bus.add_data1;
                d2 = bus.add_data2;
                if (adder_lat > 1) begin
                    repeat (adder_lat - 1) @(posedge clk);
                    #1;
                end
                bus.add_result = r2fp(fp2r(d1) + fp2r(d2));
                bus.add_update = 1'b1;
                @(posedge clk); #1;
                bus.add_update = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int   last_push_cyc = 0;
    logic saw_full = 1'b0;

    // Called at #1 after a clock edge; returns at #1 after the transfer edge.
    task automatic push(input logic [15:0] d);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && guard < 500) begin
            saw_full = 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            check_int("push_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        model_push(d);
        @(posedge clk); #1;
        last_push_cyc = cyc;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_iss.size() != 0 || exp_sum.size() != 0 || bus.busy) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_int("drain_within_budget", (guard < 3000) ? 1 : 0, 1);
    endtask

    function automatic logic [15:0] rand_elem();
        int k;
        k = int'($urandom_range(0, 64)) - 32;
        return r2fp(real'(k) / 4.0);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0, i0, g, e0;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;
        bus1.add_update = 1'b0;
        bus1.add_result = '0;
        repeat (3) @(posedge clk);
        #1;
        // reset state
        check16("rst_add_data1", bus.add_data1, 16'h0000);
        check16("rst_add_data2", bus.add_data2, 16'h0000);
        check16("rst_sum_o", bus.sum_o, 16'h0000);
        check_int("rst_add_valid", bus.add_valid, 0);
        check_int("rst_sum_valid", bus.sum_valid, 0);
        check_int("rst_busy", bus.busy, 0);
        check_int("rst_err", bus.err_timeout, 0);
        check_int("rst_in_ready", bus.in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed vector with latency check (L=2)
        adder_lat = 2;
        push(16'h5bf0);
        p0 = last_push_cyc;
        push(16'h47af);
        push(16'h0000);
        push(16'h0000);
        wait_idle();
        check16("directed_sum", bus.sum_o, 16'h5c17);
        check_int("sum_latency", last_sum_cyc - p0, 1 + 1 + (VL - 1) * (adder_lat + 1) + 1);

        // back-to-back vectors
        s0 = n_sum; i0 = n_iss;
        repeat (VL) push(16'h3c00);
        push(16'h4400); push(16'h0000); push(16'h0000); push(16'hc400);
        wait_idle();
        check16("b2b_second_sum", bus.sum_o, 16'h0000);
        check_int("b2b_sum_pulses", n_sum - s0, 2);
        check_int("b2b_add_pulses", n_iss - i0, 2 * (VL - 1));

        // backpressure with slow adder
        adder_lat = 20;
        saw_full = 1'b0;
        s0 = n_sum;
        repeat (8) push(rand_elem());
        wait_idle();
        check_int("backpressure_in_ready_dropped", saw_full, 1);
        check_int("backpressure_sums", n_sum - s0, 8 / VL);

        // randomized vectors, random adder latency and gaps
        for (int v = 0; v < 6; v++) begin
            adder_lat = int'($urandom_range(1, 4));
            for (int i = 0; i < VL; i++) begin
                push(rand_elem());
                g = int'($urandom_range(0, 3));
                repeat (g) begin @(posedge clk); #1; end
            end
        end
        wait_idle();

        // reset in WAIT of the second add
        adder_lat = 1;
        repeat (VL) push(16'h3c00);
        wait_idle();
        check16("pre_reset_sum", bus.sum_o, 16'h4400);
        adder_lat = 6;
        i0 = n_iss; s0 = n_sum;
        repeat (VL) push(rand_elem());
        g = 0;
        while (n_iss < i0 + 2 && g < 200) begin @(posedge clk); #1; g++; end
        check_int("reached_second_add", n_iss - i0, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();
        check_int("midrst_busy", bus.busy, 0);
        check_int("midrst_in_ready", bus.in_ready, 1);
        check16("midrst_sum_o", bus.sum_o, 16'h0000);
        repeat (10) begin @(posedge clk); #1; end
        check_int("stale_update_no_sum", n_sum - s0, 0);
        check_int("stale_update_idle", bus.busy, 0);
        adder_lat = 2;
        repeat (VL) push(16'h3c00);
        wait_idle();
        check16("post_reset_sum", bus.sum_o, 16'h4400);

        // VEC_LEN=1 instance: pass-through, no adds
        bus1.in_valid = 1'b1;
        bus1.in_data  = 16'hffff;
        exp_sum1.push_back(16'hffff);
        @(posedge clk); #1;
        p0 = cyc;
        bus1.in_valid = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check_int("vl1_sum_count", n_sum1, 1);
        check_int("vl1_latency", last_sum1_cyc - p0, 3);
        check16("vl1_sum_hold", bus1.sum_o, 16'hffff);

        // adder timeout
        adder_hang = 1'b1;
        s0 = n_sum; i0 = n_iss;
        push(rand_elem());
        push(rand_elem());
        g = 0;
        while (n_iss == i0 && g < 50) begin @(posedge clk); #1; g++; end
        check_int("timeout_add_issued", n_iss - i0, 1);
        e0 = last_iss_cyc;
        g = 0;
        while (!bus.err_timeout && g < 200) begin @(posedge clk); #1; g++; end
        check_int("timeout_latency", cyc - e0, TO);
        check_int("err_in_ready", bus.in_ready, 0);
        inject_cnt++;
        repeat (10) begin @(posedge clk); #1; end
        check_int("err_sticky", bus.err_timeout, 1);
        check_int("err_no_sum", n_sum - s0, 0);
        check_int("err_in_ready_after_update", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();
        adder_hang = 1'b0;
        check_int("rst_clears_err", bus.err_timeout, 0);
        check_int("rst_restores_in_ready", bus.in_ready, 1);

        repeat (5) begin @(posedge clk); #1; end
        check_int("scoreboard_drained", exp_iss.size() + exp_sum.size() + exp_sum1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
